// File: rtl/bus.sv
// Shared single-bus interconnect: two masters, two slaves, fixed-priority
// non-preemptive arbiter, address decode and one-cycle-latency read return.
module bus #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_dout,
  output logic              m0_grant,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m1_grant,
  output logic [DATA_W-1:0] m_din,
  output logic              s0_sel,
  output logic              s1_sel,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_wr,
  output logic [DATA_W-1:0] s_din,
  input  logic [DATA_W-1:0] s0_dout,
  input  logic [DATA_W-1:0] s1_dout
);

  localparam int unsigned DEC_W = 3;

  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              s0_sel_q;
  logic              s1_sel_q;
  logic [DEC_W-1:0]  region;

  // Arbiter state register; reset_n is active-high despite its name.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= GRANT_M0;
    end else begin
      state_q <= state_d;
    end
  end

  // M0 has priority but cannot take the bus back while M1 still requests it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      GRANT_M0: if (!m0_req && m1_req) state_d = GRANT_M1;
      GRANT_M1: if (!m1_req)           state_d = GRANT_M0;
      default:                         state_d = GRANT_M0;
    endcase
  end

  assign m0_grant = (state_q == GRANT_M0);
  assign m1_grant = (state_q == GRANT_M1);

  // Granted master drives the slave-side bus.
  always_comb begin
    s_address = m0_address;
    s_wr      = m0_wr;
    s_din     = m0_dout;
    if (state_q == GRANT_M1) begin
      s_address = m1_address;
      s_wr      = m1_wr;
      s_din     = m1_dout;
    end
  end

  // Top address bits pick the slave; everything above S1's window is unmapped.
  assign region = s_address[ADDR_W-1 -: DEC_W];
  assign s0_sel = (region == DEC_W'(0));
  assign s1_sel = (region == DEC_W'(1));

  // Selects remembered for one cycle to line up with synchronous slave reads.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      s0_sel_q <= 1'b0;
      s1_sel_q <= 1'b0;
    end else begin
      s0_sel_q <= s0_sel;
      s1_sel_q <= s1_sel;
    end
  end

  always_comb begin
    m_din = '0;
    if (s0_sel_q) begin
      m_din = s0_dout;
    end else if (s1_sel_q) begin
      m_din = s1_dout;
    end
  end

endmodule

// File: tb/tb_bus.sv
// Scoreboard bench for bus: a driver pushes expected outputs from a
// transaction-level model, a negedge monitor pops and compares them.
module tb_bus;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b1;
  logic              reset_n;
  logic              m0_req, m0_wr, m1_req, m1_wr;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [DATA_W-1:0] m0_dout, m1_dout;
  logic              m0_grant, m1_grant;
  logic [DATA_W-1:0] m_din;
  logic              s0_sel, s1_sel, s_wr;
  logic [ADDR_W-1:0] s_address;
  logic [DATA_W-1:0] s_din, s0_dout, s1_dout;

  bus #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m0_grant(m0_grant),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .m1_grant(m1_grant),
    .m_din(m_din), .s0_sel(s0_sel), .s1_sel(s1_sel), .s_address(s_address),
    .s_wr(s_wr), .s_din(s_din), .s0_dout(s0_dout), .s1_dout(s1_dout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              g0;
    logic              g1;
    logic              sel0;
    logic              sel1;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] mdin;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference model: who owns the bus and which slave was addressed last cycle.
  int owner     = 0;
  int prev_slv  = -1;

  function automatic int slave_of(input logic [ADDR_W-1:0] a);
    int r;
    r = int'(a) / 32;
    if (r == 0) return 0;
    if (r == 1) return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  // One bus cycle: drive inputs, predict outputs, advance model at the edge.
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                      input logic [DATA_W-1:0] d0,
                      input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
                      input logic [DATA_W-1:0] d1,
                      input logic [DATA_W-1:0] sd0, input logic [DATA_W-1:0] sd1);
    exp_t e;
    logic [ADDR_W-1:0] cur_a;
    reset_n = rst;
    m0_req = r0; m0_wr = w0; m0_address = a0; m0_dout = d0;
    m1_req = r1; m1_wr = w1; m1_address = a1; m1_dout = d1;
    s0_dout = sd0; s1_dout = sd1;
    if (rst) begin
      owner    = 0;
      prev_slv = -1;
    end
    cur_a  = (owner == 1) ? a1 : a0;
    e.g0   = (owner == 0);
    e.g1   = (owner == 1);
    e.addr = cur_a;
    e.wr   = (owner == 1) ? w1 : w0;
    e.din  = (owner == 1) ? d1 : d0;
    e.sel0 = (slave_of(cur_a) == 0);
    e.sel1 = (slave_of(cur_a) == 1);
    e.mdin = (prev_slv == 0) ? sd0 : (prev_slv == 1) ? sd1 : '0;
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      prev_slv = slave_of(cur_a);
      if (owner == 0 && !r0 && r1) owner = 1;
      else if (owner == 1 && !r1)  owner = 0;
    end
    #1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m0_grant",  DATA_W'(m0_grant),  DATA_W'(e.g0));
        chk("m1_grant",  DATA_W'(m1_grant),  DATA_W'(e.g1));
        chk("s0_sel",    DATA_W'(s0_sel),    DATA_W'(e.sel0));
        chk("s1_sel",    DATA_W'(s1_sel),    DATA_W'(e.sel1));
        chk("s_wr",      DATA_W'(s_wr),      DATA_W'(e.wr));
        chk("s_address", DATA_W'(s_address), DATA_W'(e.addr));
        chk("s_din",     s_din,              e.din);
        chk("m_din",     m_din,              e.mdin);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic              r0, r1, w0, w1, rst;
    logic [ADDR_W-1:0] a0, a1;
    // Reset, then idle with M0 keeping the grant.
    step(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 32'h11, 32'h22);
    step(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 32'h11, 32'h22);
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 32'h11, 32'h22);
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 32'h11, 32'h22);
    // M0 write sweep into S0.
    for (int i = 1; i <= 3; i++)
      step(0, 1, 1, ADDR_W'(i), DATA_W'(2 * i), 0, 0, 8'h00, 0, 0, 0);
    // S1 window and an unmapped address.
    for (int i = 0; i < 4; i++)
      step(0, 1, 1, ADDR_W'(8'h20 + i), DATA_W'(32'h20 + 2 * i), 0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 1, 8'hA0, 32'h99, 0, 0, 8'h00, 0, 0, 0);
    // Read latency: S0 returns 1, S1 returns 2.
    step(0, 1, 0, 8'h01, 0, 0, 0, 8'h00, 0, 1, 2);
    step(0, 1, 0, 8'h21, 0, 0, 0, 8'h00, 0, 1, 2);
    step(0, 1, 0, 8'hA0, 0, 0, 0, 8'h00, 0, 1, 2);
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 2);
    // Arbitration: both request, M0 drops, M0 returns, M1 drops.
    step(0, 1, 0, 8'h02, 32'hA, 1, 0, 8'h22, 32'hB, 5, 6);
    step(0, 1, 0, 8'h02, 32'hA, 1, 0, 8'h22, 32'hB, 5, 6);
    step(0, 0, 0, 8'h02, 32'hA, 1, 1, 8'h23, 32'hC, 5, 6);
    step(0, 0, 0, 8'h02, 32'hA, 1, 1, 8'h04, 32'hD, 5, 6);
    step(0, 1, 1, 8'h05, 32'hE, 1, 0, 8'h24, 32'hF, 5, 6);
    step(0, 1, 1, 8'h05, 32'hE, 1, 0, 8'h24, 32'hF, 5, 6);
    step(0, 1, 1, 8'h06, 32'hE, 0, 0, 8'h24, 32'hF, 5, 6);
    step(0, 1, 1, 8'h07, 32'hE, 0, 0, 8'h24, 32'hF, 5, 6);
    // Async reset while M1 owns the bus with a read in flight.
    step(0, 0, 0, 8'h00, 0, 1, 0, 8'h21, 0, 7, 8);
    step(0, 0, 0, 8'h00, 0, 1, 0, 8'h21, 0, 7, 8);
    step(1, 0, 0, 8'h00, 0, 1, 0, 8'h21, 0, 7, 8);
    step(0, 0, 0, 8'h00, 0, 1, 0, 8'h21, 0, 7, 8);
    step(0, 0, 0, 8'h00, 0, 1, 0, 8'h21, 0, 7, 8);
    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      r0  = ($urandom_range(0, 99) < 55);
      r1  = ($urandom_range(0, 99) < 55);
      w0  = r0 & $urandom_range(0, 1);
      w1  = r1 & $urandom_range(0, 1);
      a0  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 63));
      a1  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 63));
      step(rst, r0, w0, a0, $urandom, r1, w1, a1, $urandom, $urandom, $urandom);
    end
    @(negedge clk);
    done = 1;
    chk("scoreboard_drained", DATA_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
